fetch_decode_queue: RTL and testbench

//   Parametrised F->D instruction queue that replaces the single fetch/decode pipeline register.
//   It buffers up to DEPTH fetched entries {instr, PC, PCPlus4}, so fetch can run ahead while decode stalls.
//   A single-cycle flush discards the whole queue when a branch or jump is taken.

---
 rtl/fetch_decode_queue.sv | 80 ++++++++
 tb/tb_fetch_decode_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// F->D instruction queue: circular buffer of {instr, PC, PCPlus4} between fetch and decode.
// Head outputs come from registered state only; flush empties the queue in one cycle.
module fetch_decode_queue #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_F,
  input  logic [WIDTH-1:0]         instr_F,
  input  logic [WIDTH-1:0]         PC_F,
  input  logic [WIDTH-1:0]         PCPlus4_F,
  output logic                     ready_F,
  input  logic                     stall_D,
  input  logic                     flush_D,
  output logic                     valid_D,
  output logic [WIDTH-1:0]         instr_D,
  output logic [WIDTH-1:0]         PC_D,
  output logic [WIDTH-1:0]         PCPlus4_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] pcp4_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  assign valid_D = (count_q != '0);
  assign ready_F = (count_q < CW'(DEPTH));
  assign push    = valid_F & ready_F;
  assign pop     = valid_D & ~stall_D;
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_D) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush_D && push) begin
      instr_mem[wr_ptr] <= instr_F;
      pc_mem[wr_ptr]    <= PC_F;
      pcp4_mem[wr_ptr]  <= PCPlus4_F;
    end
  end

  always_comb begin
    instr_D   = NOP_INSTR;
    PC_D      = '0;
    PCPlus4_D = '0;
    if (valid_D) begin
      instr_D   = instr_mem[rd_ptr];
      PC_D      = pc_mem[rd_ptr];
      PCPlus4_D = pcp4_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: scoreboard queue of expected entries checked by a
// negedge monitor, plus directed checks of hand-computed values at key points.
module tb_fetch_decode_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_F;
  logic [WIDTH-1:0] instr_F, PC_F, PCPlus4_F;
  logic             ready_F;
  logic             stall_D, flush_D;
  logic             valid_D;
  logic [WIDTH-1:0] instr_D, PC_D, PCPlus4_D;
  logic [2:0]       count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .valid_F(valid_F), .instr_F(instr_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F),
    .ready_F(ready_F),
    .stall_D(stall_D), .flush_D(flush_D),
    .valid_D(valid_D), .instr_D(instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs applied here take effect at the next rising edge; returns 1ns after it.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic st, input logic fl);
    valid_F   = v;
    instr_F   = ins;
    PC_F      = pc;
    PCPlus4_F = pc + 32'd4;
    stall_D   = st;
    flush_D   = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: reference occupancy is the scoreboard size; pops compare the head, pushes append.
  always @(negedge clk) begin
    int sz;
    if (rst) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("mon_count", 32'(count), 32'(sz));
      chk("mon_valid_D", 32'(valid_D), 32'(sz != 0));
      chk("mon_ready_F", 32'(ready_F), 32'(sz < DEPTH));
      if (sz != 0) begin
        chk("mon_instr_D", instr_D, exp_q[0].instr);
        chk("mon_PC_D", PC_D, exp_q[0].pc);
        chk("mon_PCPlus4_D", PCPlus4_D, exp_q[0].pcp4);
      end else begin
        chk("mon_empty_instr", instr_D, NOP);
        chk("mon_empty_PC", PC_D, 32'h0);
        chk("mon_empty_PCPlus4", PCPlus4_D, 32'h0);
      end
      if (flush_D) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && !stall_D) void'(exp_q.pop_front());
        if (valid_F && sz < DEPTH) exp_q.push_back('{instr_F, PC_F, PC_F + 32'd4});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] stall_pat;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;

    // reset state
    chk("rst_valid_D", 32'(valid_D), 0);
    chk("rst_instr_D", instr_D, 32'h00000013);
    chk("rst_PC_D", PC_D, 0);
    chk("rst_ready_F", 32'(ready_F), 1);
    chk("rst_count", 32'(count), 0);

    // streaming, no stall: count never above 1
    cyc(1, 32'h11, 32'h0, 0, 0);
    chk("s2_valid", 32'(valid_D), 1);
    chk("s2_pc0", PC_D, 32'h0);
    chk("s2_cnt0", 32'(count), 1);
    cyc(1, 32'h22, 32'h4, 0, 0);
    chk("s2_pc4", PC_D, 32'h4);
    chk("s2_cnt1", 32'(count), 1);
    cyc(1, 32'h33, 32'h8, 0, 0);
    chk("s2_pc8", PC_D, 32'h8);
    chk("s2_instr", instr_D, 32'h33);
    chk("s2_cnt2", 32'(count), 1);
    cyc(0, 0, 0, 0, 0);
    chk("s2_empty", 32'(valid_D), 0);

    // fill while stalled; fifth entry rejected
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'hA0 + 32'(i), 32'(4 * i), 1, 0);
      if (i == 3) begin
        chk("s3_full_cnt", 32'(count), 4);
        chk("s3_full_ready", 32'(ready_F), 0);
      end
    end
    chk("s3_cnt_after5", 32'(count), 4);
    chk("s3_head0", PC_D, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("s3_head4", PC_D, 32'h4);
    cyc(0, 0, 0, 0, 0);
    chk("s3_head8", PC_D, 32'h8);
    cyc(0, 0, 0, 0, 0);
    chk("s3_headC", PC_D, 32'hC);
    chk("s3_instrC", instr_D, 32'hA3);
    cyc(0, 0, 0, 0, 0);
    chk("s3_drained", 32'(valid_D), 0);

    // simultaneous push and pop at count 2
    cyc(1, 32'h55, 32'h20, 1, 0);
    cyc(1, 32'h56, 32'h24, 1, 0);
    chk("s4_cnt2", 32'(count), 2);
    cyc(1, 32'h57, 32'h28, 0, 0);
    chk("s4_cnt_same", 32'(count), 2);
    chk("s4_head", PC_D, 32'h24);
    cyc(0, 0, 0, 0, 0);
    chk("s4_head28", PC_D, 32'h28);
    cyc(0, 0, 0, 0, 0);
    chk("s4_empty", 32'(count), 0);

    // flush with a concurrent push
    cyc(1, 32'h61, 32'h30, 1, 0);
    cyc(1, 32'h62, 32'h34, 1, 0);
    cyc(1, 32'h63, 32'h38, 1, 0);
    chk("s5_cnt3", 32'(count), 3);
    cyc(1, 32'h64, 32'h40, 0, 1);
    chk("s5_flush_cnt", 32'(count), 0);
    chk("s5_flush_valid", 32'(valid_D), 0);
    cyc(1, 32'h65, 32'h80, 1, 0);
    chk("s5_head80", PC_D, 32'h80);
    chk("s5_cnt1", 32'(count), 1);
    cyc(0, 0, 0, 0, 0);
    chk("s5_empty", 32'(valid_D), 0);

    // wrap-around with varying stall; order checked by the scoreboard
    stall_pat = 10'b0110010110;
    for (int i = 0; i < 10; i++)
      cyc(1, 32'h200 + 32'(i), 32'h100 + 32'(4 * i), stall_pat[i], 0);
    for (int i = 0; i < 8 && valid_D; i++)
      cyc(0, 0, 0, 0, 0);
    chk("s6_drained_cnt", 32'(count), 0);
    chk("s6_sb_empty", 32'(exp_q.size()), 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
